// File: rtl/gift_decrypt_core.sv
// gift_decrypt_core: iterative GIFT-128 block decryption, one inverse round per clock.
// A job is accepted in IDLE. The key state is then rolled forward 39 times in KEYEXP to
// reach the round-39 key state. DEC runs the 40 inverse rounds, rolling the key state and
// round constant backwards as it goes. DONE holds the plaintext until the downstream accepts it.
// Optional build macro: GIFT_DEC_KEY_CACHE_EN caches the last master key and its round-39
// key state, so a job with a repeated key skips KEYEXP.
// Ports:
//   inClock            rising-edge clock
//   inResetN           synchronous active-low reset
//   inValid / outReady job handshake (outReady is high only in IDLE)
//   inCipher, inKey    128-bit ciphertext and master key
//   outValid / inReady result handshake
//   outPlain           128-bit plaintext, zero except while outValid
//   outBusy            high in KEYEXP or DEC
module gift_decrypt_core #(
  parameter int unsigned ROUNDS     = 40,
  parameter logic [5:0]  LAST_CONST = 6'h1A
) (
  input  logic         inClock,
  input  logic         inResetN,
  input  logic         inValid,
  output logic         outReady,
  input  logic [127:0] inCipher,
  input  logic [127:0] inKey,
  output logic         outValid,
  input  logic         inReady,
  output logic [127:0] outPlain,
  output logic         outBusy
);

  localparam int unsigned    CNT_W       = 6;
  localparam logic [CNT_W-1:0] LAST_ROUND  = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] LAST_KEYEXP = CNT_W'(ROUNDS - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    DEC    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state;
  logic [127:0]       data_reg;
  logic [127:0]       key_reg;
  logic [5:0]         const_reg;
  logic [CNT_W-1:0]   round_cnt;

  // Forward GIFT-128 bit permutation: source bit i lands on bit perm_idx(i).
  function automatic int unsigned perm_idx(input int unsigned i);
    return 4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hD;  4'h1: y = 4'h0;  4'h2: y = 4'h8;  4'h3: y = 4'h6;
      4'h4: y = 4'h2;  4'h5: y = 4'hC;  4'h6: y = 4'h4;  4'h7: y = 4'hB;
      4'h8: y = 4'hE;  4'h9: y = 4'h7;  4'hA: y = 4'h1;  4'hB: y = 4'hA;
      4'hC: y = 4'h3;  4'hD: y = 4'h9;  4'hE: y = 4'hF;  default: y = 4'h5;
    endcase
    return y;
  endfunction

  // Key state words: k0 = key[15:0] ... k7 = key[127:112].
  logic [127:0] key_fwd;
  logic [127:0] key_inv;
  assign key_fwd = {key_reg[17:16], key_reg[31:18], key_reg[11:0], key_reg[15:12], key_reg[127:32]};
  assign key_inv = {key_reg[95:0], key_reg[125:112], key_reg[127:126], key_reg[99:96], key_reg[111:100]};

  logic [5:0] const_inv;
  assign const_inv = {const_reg[0] ^ const_reg[5] ^ 1'b1, const_reg[5:1]};

  // Undo AddRoundKey: U = k5||k4 feeds bit 4i+2 and V = k1||k0 feeds bit 4i+1.
  logic [127:0] rk_mask;
  logic [127:0] const_mask;
  logic [127:0] add_out;
  logic [127:0] perm_out;
  logic [127:0] round_out;

  for (genvar i = 0; i < 32; i++) begin : g_rk
    assign rk_mask[4*i +: 4] = {1'b0, key_reg[64+i], key_reg[i], 1'b0};
  end

  assign const_mask = {1'b1, 103'b0,
                       const_reg[5], 3'b0, const_reg[4], 3'b0, const_reg[3], 3'b0,
                       const_reg[2], 3'b0, const_reg[1], 3'b0, const_reg[0], 3'b0};
  assign add_out    = data_reg ^ rk_mask ^ const_mask;

  // Inverse permutation pulls each bit back from where PermBits sent it.
  for (genvar j = 0; j < 128; j++) begin : g_perm
    localparam int unsigned SRC = perm_idx(j);
    assign perm_out[j] = add_out[SRC];
  end

  for (genvar i = 0; i < 32; i++) begin : g_sbox
    assign round_out[4*i +: 4] = inv_sbox(perm_out[4*i +: 4]);
  end

`ifdef GIFT_DEC_KEY_CACHE_EN
  logic [127:0] cache_key;
  logic [127:0] cache_state;
  logic         cache_valid;
  logic         cache_hit;
  assign cache_hit = cache_valid && (inKey == cache_key);
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge inClock) begin
    if (!inResetN) begin
      state     <= IDLE;
      data_reg  <= '0;
      key_reg   <= '0;
      const_reg <= '0;
      round_cnt <= '0;
      outValid  <= 1'b0;
      outPlain  <= '0;
      outBusy   <= 1'b0;
      outReady  <= 1'b1;
`ifdef GIFT_DEC_KEY_CACHE_EN
      cache_key   <= '0;
      cache_state <= '0;
      cache_valid <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (inValid && outReady) begin
            data_reg <= inCipher;
            outReady <= 1'b0;
            outBusy  <= 1'b1;
`ifdef GIFT_DEC_KEY_CACHE_EN
            if (cache_hit) begin
              key_reg   <= cache_state;
              const_reg <= LAST_CONST;
              round_cnt <= LAST_ROUND;
              state     <= DEC;
            end else begin
              // Invalidate until the matching round-39 state is written.
              key_reg     <= inKey;
              cache_key   <= inKey;
              cache_valid <= 1'b0;
              round_cnt   <= '0;
              state       <= KEYEXP;
            end
`else
            key_reg   <= inKey;
            round_cnt <= '0;
            state     <= KEYEXP;
`endif
          end
        end
        KEYEXP: begin
          key_reg <= key_fwd;
          if (round_cnt == LAST_KEYEXP) begin
            const_reg <= LAST_CONST;
            round_cnt <= LAST_ROUND;
            state     <= DEC;
`ifdef GIFT_DEC_KEY_CACHE_EN
            cache_state <= key_fwd;
            cache_valid <= 1'b1;
`endif
          end else begin
            round_cnt <= round_cnt + CNT_W'(1);
          end
        end
        DEC: begin
          data_reg  <= round_out;
          key_reg   <= key_inv;
          const_reg <= const_inv;
          if (round_cnt == '0) begin
            outBusy <= 1'b0;
            state   <= DONE;
          end else begin
            round_cnt <= round_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // Output goes valid one cycle after entering DONE, then waits for the sink.
          if (!outValid) begin
            outValid <= 1'b1;
            outPlain <= data_reg;
          end else if (inReady) begin
            outValid <= 1'b0;
            outPlain <= '0;
            outReady <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gift_decrypt_core.sv
// tb_gift_decrypt_core: directed bench for gift_decrypt_core. Ciphertexts come from a small
// forward GIFT-128 model, or from the published all-zero test vector. Each result is checked
// against the chosen plaintext, and each latency is checked against a small cache model.
module tb_gift_decrypt_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] cipher;
  logic [127:0] key;
  logic         out_valid;
  logic         in_ready;
  logic [127:0] plain;
  logic         busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [127:0] model_key   = '0;
  bit           model_valid = 1'b0;

  always #5 clk = ~clk;

  gift_decrypt_core dut (
    .inClock  (clk),
    .inResetN (rst_n),
    .inValid  (in_valid),
    .outReady (out_ready),
    .inCipher (cipher),
    .inKey    (key),
    .outValid (out_valid),
    .inReady  (in_ready),
    .outPlain (plain),
    .outBusy  (busy)
  );

  // Forward GIFT-128 reference.
  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h1;  4'h1: y = 4'hA;  4'h2: y = 4'h4;  4'h3: y = 4'hC;
      4'h4: y = 4'h6;  4'h5: y = 4'hF;  4'h6: y = 4'h3;  4'h7: y = 4'h9;
      4'h8: y = 4'h2;  4'h9: y = 4'hD;  4'hA: y = 4'hB;  4'hB: y = 4'h7;
      4'hC: y = 4'h5;  4'hD: y = 4'h0;  4'hE: y = 4'h8;  default: y = 4'hE;
    endcase
    return y;
  endfunction

  function automatic logic [6:0] perm_fwd(input int unsigned i);
    return 7'(4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4));
  endfunction

  function automatic logic [127:0] gift_enc(input logic [127:0] pt, input logic [127:0] k_in);
    logic [127:0] s;
    logic [127:0] p;
    logic [127:0] k;
    logic [5:0]   c;
    s = pt;
    k = k_in;
    c = '0;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 32; i++) s[4*i +: 4] = sbox_fwd(s[4*i +: 4]);
      p = '0;
      for (int i = 0; i < 128; i++) p[perm_fwd(i)] = s[i];
      s = p;
      c = {c[4:0], c[5] ^ c[4] ^ 1'b1};
      for (int i = 0; i < 32; i++) begin
        s[4*i+2] = s[4*i+2] ^ k[64+i];
        s[4*i+1] = s[4*i+1] ^ k[i];
      end
      s[23]  = s[23] ^ c[5];
      s[19]  = s[19] ^ c[4];
      s[15]  = s[15] ^ c[3];
      s[11]  = s[11] ^ c[2];
      s[7]   = s[7]  ^ c[1];
      s[3]   = s[3]  ^ c[0];
      s[127] = ~s[127];
      k = {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
    end
    return s;
  endfunction

  // Expected accept-to-valid latency, tracking the optional key cache.
  task automatic expect_latency(input logic [127:0] k, output int lat);
`ifdef GIFT_DEC_KEY_CACHE_EN
    if (model_valid && k == model_key) begin
      lat = 41;
    end else begin
      lat = 80;
      model_key   = k;
      model_valid = 1'b1;
    end
`else
    lat = 80;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for outReady (bounded), then present one job for exactly one accepting edge.
  task automatic start_job(input logic [127:0] ct, input logic [127:0] k, output bit ok);
    int n = 0;
    while (!out_ready && n < 300) begin
      tick();
      n++;
    end
    ok       = out_ready;
    in_valid = 1'b1;
    cipher   = ct;
    key      = k;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_ready = 1'b1;
    cipher   = '0;
    key      = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (out_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", out_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests_run++;
    if (plain !== 128'h0) begin tests_failed++; $display("FAIL reset_plain: got %h want 0", plain); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_known_vector();
    bit ok;
    int lat;
    int exp_lat;
    expect_latency(128'h0, exp_lat);
    start_job(128'hcd0bd738388ad3f668b15a36ceb6ff92, 128'h0, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL kv_accept: ready got %b want 1", ok); end
    tests_run++;
    if ({busy, out_ready} !== 2'b10) begin tests_failed++; $display("FAIL kv_busy: busy/ready got %b want 10", {busy, out_ready}); end
    wait_valid(lat);
    tests_run++;
    if (lat != exp_lat) begin tests_failed++; $display("FAIL kv_latency: got %0d want %0d", lat, exp_lat); end
    tests_run++;
    if (plain !== 128'h0) begin tests_failed++; $display("FAIL kv_plain: got %h want 0", plain); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL kv_done_busy: got %b want 0", busy); end
    tick();
    tests_run++;
    if ({out_valid, out_ready, plain} !== {1'b0, 1'b1, 128'h0}) begin
      tests_failed++;
      $display("FAIL kv_release: valid %b ready %b plain %h want 0 1 0", out_valid, out_ready, plain);
    end
  endtask

  task automatic test_roundtrip();
    logic [127:0] pts  [8];
    logic [127:0] keys [8];
    logic [127:0] ct;
    bit ok;
    int lat;
    int exp_lat;
    pts[0] = 128'hfedcba9876543210fedcba9876543210; keys[0] = 128'hfedcba9876543210fedcba9876543210;
    pts[1] = 128'hffffffffffffffffffffffffffffffff; keys[1] = 128'h00000000000000000000000000000001;
    pts[2] = 128'h0123456789abcdef0123456789abcdef; keys[2] = 128'hffffffffffffffffffffffffffffffff;
    pts[3] = 128'h80000000000000000000000000000000; keys[3] = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
    for (int v = 4; v < 8; v++) begin
      pts[v]  = {$urandom, $urandom, $urandom, $urandom};
      keys[v] = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int v = 0; v < 8; v++) begin
      ct = gift_enc(pts[v], keys[v]);
      expect_latency(keys[v], exp_lat);
      start_job(ct, keys[v], ok);
      wait_valid(lat);
      tests_run++;
      if (plain !== pts[v] || lat != exp_lat) begin
        tests_failed++;
        $display("FAIL roundtrip_%0d: plain %h lat %0d want %h lat %0d", v, plain, lat, pts[v], exp_lat);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] pt = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] k  = 128'h1111222233334444555566667777aaaa;
    bit ok;
    int lat;
    int exp_lat;
    in_ready = 1'b0;
    expect_latency(k, exp_lat);
    start_job(gift_enc(pt, k), k, ok);
    wait_valid(lat);
    tests_run++;
    if (plain !== pt || lat != exp_lat) begin
      tests_failed++;
      $display("FAIL bp_result: plain %h lat %0d want %h lat %0d", plain, lat, pt, exp_lat);
    end
    for (int i = 0; i < 20; i++) begin
      in_valid = (i >= 5 && i < 9);
      cipher   = 128'hdeadbeef;
      key      = 128'h5;
      tick();
      tests_run++;
      if ({out_valid, out_ready, plain} !== {1'b1, 1'b0, pt}) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: valid %b ready %b plain %h want 1 0 %h", i, out_valid, out_ready, plain, pt);
      end
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    tick();
    tests_run++;
    if ({out_valid, out_ready, plain} !== {1'b0, 1'b1, 128'h0}) begin
      tests_failed++;
      $display("FAIL bp_release: valid %b ready %b plain %h want 0 1 0", out_valid, out_ready, plain);
    end
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if ({busy, out_valid, out_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL bp_ignored_job: busy/valid/ready got %b want 001", {busy, out_valid, out_ready});
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k  = 128'h0badc0de0badc0de0badc0de0badc0de;
    logic [127:0] p1 = 128'h13579bdf2468ace013579bdf2468ace0;
    logic [127:0] p2 = 128'hcafef00dcafef00dcafef00dcafef00d;
    bit ok;
    int lat;
    int exp_lat;
    int n = 0;
    expect_latency(k, exp_lat);
    start_job(gift_enc(p1, k), k, ok);
    while (dut.round_cnt != 6'd39 && n < 200) begin tick(); n++; end
    for (int i = 0; i < 19; i++) tick();
    tests_run++;
    if (dut.round_cnt !== 6'd20 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_reach: round_cnt %0d busy %b want 20 1", dut.round_cnt, busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_valid = 1'b0;
    tests_run++;
    if ({out_ready, out_valid, busy, plain} !== {1'b1, 1'b0, 1'b0, 128'h0}) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: ready %b valid %b busy %b plain %h want 1 0 0 0", out_ready, out_valid, busy, plain);
    end
    tests_run++;
    if ({dut.data_reg, dut.key_reg, dut.const_reg} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_regs: data %h key %h const %h want 0", dut.data_reg, dut.key_reg, dut.const_reg);
    end
    expect_latency(k, exp_lat);
    start_job(gift_enc(p2, k), k, ok);
    wait_valid(lat);
    tests_run++;
    if (plain !== p2 || lat != exp_lat) begin
      tests_failed++;
      $display("FAIL rst_mid_next_job: plain %h lat %0d want %h lat %0d", plain, lat, p2, exp_lat);
    end
    tick();
  endtask

  task automatic test_const_seq();
    logic [127:0] k  = 128'h2718281828459045235360287471352a;
    logic [127:0] pt = 128'h31415926535897932384626433832795;
    bit ok;
    int lat;
    int exp_lat;
    int n = 0;
    expect_latency(k, exp_lat);
    start_job(gift_enc(pt, k), k, ok);
    while (dut.round_cnt != 6'd39 && n < 200) begin tick(); n++; end
    tests_run++;
    if (dut.const_reg !== 6'h1A) begin tests_failed++; $display("FAIL const_first: got %h want 1a", dut.const_reg); end
    tick();
    tests_run++;
    if (dut.const_reg !== 6'h2D) begin tests_failed++; $display("FAIL const_second: got %h want 2d", dut.const_reg); end
    tick();
    tests_run++;
    if (dut.const_reg !== 6'h36) begin tests_failed++; $display("FAIL const_third: got %h want 36", dut.const_reg); end
    for (int i = 0; i < 37; i++) tick();
    tests_run++;
    if (dut.round_cnt !== 6'd0 || dut.const_reg !== 6'h01) begin
      tests_failed++;
      $display("FAIL const_last: round_cnt %0d const %h want 0 01", dut.round_cnt, dut.const_reg);
    end
    wait_valid(lat);
    tests_run++;
    if (plain !== pt) begin tests_failed++; $display("FAIL const_plain: got %h want %h", plain, pt); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka = 128'h0c0c0c0c1d1d1d1d2e2e2e2e3f3f3f3f;
    logic [127:0] kb = 128'h99998888777766665555444433332222;
    logic [127:0] pts  [3];
    logic [127:0] keys [3];
    bit ok;
    int lat;
    int exp_lat;
    pts[0] = 128'haaaaaaaa55555555aaaaaaaa55555555; keys[0] = ka;
    pts[1] = 128'h0000000100000002000000030000000f; keys[1] = ka;
    pts[2] = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f; keys[2] = kb;
    for (int j = 0; j < 3; j++) begin
      expect_latency(keys[j], exp_lat);
      start_job(gift_enc(pts[j], keys[j]), keys[j], ok);
      wait_valid(lat);
      tests_run++;
      if (plain !== pts[j] || lat != exp_lat) begin
        tests_failed++;
        $display("FAIL b2b_%0d: plain %h lat %0d want %h lat %0d", j, plain, lat, pts[j], exp_lat);
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_known_vector();
    test_roundtrip();
    test_backpressure();
    test_reset_mid();
    test_const_seq();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
